// File: rtl/rv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_pkg : RV32I opcodes, funct3 codes, FSM state codes, immediates  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rv_pkg;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_READ   = 2'd1;
  localparam state_t S_EXEC   = 2'd2;
  localparam state_t S_HALTED = 2'd3;

  // Decoders take only the instruction fields they consume.
  function automatic logic [31:0] imm_i(input logic [11:0] f);
    return {{20{f[11]}}, f};
  endfunction

  function automatic logic [31:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, hi, lo};
  endfunction

  function automatic logic [31:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [19:0] u);
    return {u, 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [19:0] u);
    return {{12{u[19]}}, u[7:0], u[8], u[18:9], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_execute_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_execute_if : fetch <-> execute handshake and retire bus         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface rv_execute_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        done;
  logic [31:0] next_pc;
  logic        halt;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic        is_mem;
  logic [31:0] dbg_x1;

  modport master (
    output inst_valid, inst, pc,
    input  inst_ready, done, next_pc, halt, mem_addr, store_data, is_mem, dbg_x1
  );

  modport slave (
    input  inst_valid, inst, pc,
    output inst_ready, done, next_pc, halt, mem_addr, store_data, is_mem, dbg_x1
  );
endinterface
`default_nettype wire

// File: rtl/rv_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_alu : combinational RV32I integer ALU                           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rv_alu
  import rv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_sub_i,
  input  logic        is_sra_i,
  output logic [31:0] result_o
);

  logic [4:0] w_shamt;
  assign w_shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (funct3_i)
      F3_ADD:  result_o = is_sub_i ? (a_i - b_i) : (a_i + b_i);
      F3_SLL:  result_o = a_i << w_shamt;
      F3_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      F3_SLTU: result_o = {31'd0, a_i < b_i};
      F3_XOR:  result_o = a_i ^ b_i;
      F3_SR:   result_o = is_sra_i ? $unsigned($signed(a_i) >>> w_shamt) : (a_i >> w_shamt);
      F3_OR:   result_o = a_i | b_i;
      F3_AND:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_execute.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_execute : multi-cycle RV32I execute/writeback with register file|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rv_execute
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         CLK,
  input  logic         RESET,
  rv_execute_if.slave  bus
);

  state_t      state_q, state_d;
  logic [31:0] inst_q, pc_q;
  logic [31:0] rs1_q, rs2_q;
  logic [31:0] next_pc_q;
  logic        halt_q;
  logic [31:0] regs_q [32];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_is_alureg, w_is_aluimm, w_is_branch, w_is_jal, w_is_jalr;
  logic        w_is_load, w_is_store, w_is_system;
  logic [31:0] w_alu_b, w_alu_res;
  logic        w_taken;
  logic        w_wb_en;
  logic [31:0] w_wb_data;
  logic [31:0] w_next_pc;
  logic        w_ready, w_accept, w_done;

  assign w_opcode = inst_q[6:0];
  assign w_rd     = inst_q[11:7];
  assign w_f3     = inst_q[14:12];
  assign w_rs1    = inst_q[19:15];
  assign w_rs2    = inst_q[24:20];

  assign w_imm_i = imm_i(inst_q[31:20]);
  assign w_imm_s = imm_s(inst_q[31:25], inst_q[11:7]);
  assign w_imm_b = imm_b(inst_q[31:25], inst_q[11:7]);
  assign w_imm_u = imm_u(inst_q[31:12]);
  assign w_imm_j = imm_j(inst_q[31:12]);

  assign w_is_alureg = (w_opcode == OP_ALUREG);
  assign w_is_aluimm = (w_opcode == OP_ALUIMM);
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_jal    = (w_opcode == OP_JAL);
  assign w_is_jalr   = (w_opcode == OP_JALR);
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_system = (w_opcode == OP_SYSTEM);

  assign w_alu_b = w_is_alureg ? rs2_q : w_imm_i;

  rv_alu u_alu (
    .a_i      (rs1_q),
    .b_i      (w_alu_b),
    .funct3_i (w_f3),
    .is_sub_i (w_is_alureg && inst_q[30]),
    .is_sra_i (inst_q[30]),
    .result_o (w_alu_res)
  );

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      F3_BEQ:  w_taken = (rs1_q == rs2_q);
      F3_BNE:  w_taken = (rs1_q != rs2_q);
      F3_BLT:  w_taken = ($signed(rs1_q) <  $signed(rs2_q));
      F3_BGE:  w_taken = ($signed(rs1_q) >= $signed(rs2_q));
      F3_BLTU: w_taken = (rs1_q <  rs2_q);
      F3_BGEU: w_taken = (rs1_q >= rs2_q);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_data = w_alu_res;
    case (w_opcode)
      OP_ALUREG, OP_ALUIMM: w_wb_en = 1'b1;
      OP_JAL, OP_JALR: begin
        w_wb_en   = 1'b1;
        w_wb_data = pc_q + 32'd4;
      end
      OP_LUI: begin
        w_wb_en   = 1'b1;
        w_wb_data = w_imm_u;
      end
      OP_AUIPC: begin
        w_wb_en   = 1'b1;
        w_wb_data = pc_q + w_imm_u;
      end
      default: w_wb_en = 1'b0;
    endcase
    if (w_rd == 5'd0) begin
      w_wb_en = 1'b0;
    end
  end

  // JALR target uses the rs1 snapshot from READ, so rd==rs1 is safe.
  always_comb begin
    w_next_pc = pc_q + 32'd4;
    if (w_is_jal) begin
      w_next_pc = pc_q + w_imm_j;
    end else if (w_is_jalr) begin
      w_next_pc = (rs1_q + w_imm_i) & ~32'd1;
    end else if (w_is_branch && w_taken) begin
      w_next_pc = pc_q + w_imm_b;
    end
  end

  assign w_ready  = (state_q == S_IDLE) && !halt_q && !RESET;
  assign w_accept = w_ready && bus.inst_valid;
  assign w_done   = (state_q == S_EXEC) && !RESET;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = w_is_system ? S_HALTED : S_IDLE;
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      next_pc_q <= RESET_PC;
      halt_q    <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        inst_q <= bus.inst;
        pc_q   <= bus.pc;
      end
      if (state_q == S_READ) begin
        rs1_q <= (w_rs1 == 5'd0) ? 32'd0 : regs_q[w_rs1];
        rs2_q <= (w_rs2 == 5'd0) ? 32'd0 : regs_q[w_rs2];
      end
      if (state_q == S_EXEC) begin
        next_pc_q <= w_next_pc;
        if (w_is_system) begin
          halt_q <= 1'b1;
        end
        if (w_wb_en) begin
          regs_q[w_rd] <= w_wb_data;
        end
      end
    end
  end

  assign bus.inst_ready = w_ready;
  assign bus.done       = w_done;
  assign bus.next_pc    = w_done ? w_next_pc : next_pc_q;
  assign bus.halt       = halt_q;
  assign bus.is_mem     = w_done && (w_is_load || w_is_store);
  assign bus.mem_addr   = rs1_q + (w_is_store ? w_imm_s : w_imm_i);
  assign bus.store_data = rs2_q;
  assign bus.dbg_x1     = regs_q[1];

endmodule
`default_nettype wire

// File: tb/tb_rv_execute.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rv_execute : directed ISA-level bench with an instruction model |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rv_execute;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [6:0]  OPI = 7'b0010011;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  rv_execute_if bus ();

  rv_execute #(.RESET_PC(RESET_PC)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int          due;
    logic [31:0] npc;
    logic [31:0] maddr;
    logic [31:0] sdata;
    logic [31:0] x1;
    logic        is_mem;
    logic        halt;
  } ret_t;

  ret_t        q[$];
  logic [31:0] mregs [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          started = 1'b0;
  logic [31:0] cur_pc = 32'h0;

  logic [31:0] exp_npc = RESET_PC;
  logic [31:0] exp_x1 = 32'h0;
  logic        exp_halt = 1'b0;
  logic        exp_done;
  ret_t        head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic sub, input logic sra);
    case (f3)
      3'd0: return sub ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sra ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Architectural effect of one instruction on the model register file.
  task automatic model_exec(input logic [31:0] ins, input logic [31:0] pc, output ret_t r);
    logic [31:0] a, b, iimm, simm, bimm, uimm, jimm, wv;
    logic        wr, tk;
    logic [2:0]  f3;
    a    = mregs[ins[19:15]];
    b    = mregs[ins[24:20]];
    f3   = ins[14:12];
    iimm = {{20{ins[31]}}, ins[31:20]};
    simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    uimm = {ins[31:12], 12'b0};
    jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    r = '0;
    r.npc   = pc + 32'd4;
    r.sdata = b;
    wr = 1'b0;
    wv = 32'd0;
    case (ins[6:0])
      7'b0110011: begin wr = 1'b1; wv = alu(f3, a, b, ins[30], ins[30]); end
      7'b0010011: begin wr = 1'b1; wv = alu(f3, a, iimm, 1'b0, ins[30]); end
      7'b1100011: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = $signed(a) < $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a < b;
          3'd7: tk = a >= b;
          default: tk = 1'b0;
        endcase
        if (tk) r.npc = pc + bimm;
      end
      7'b1101111: begin wr = 1'b1; wv = pc + 32'd4; r.npc = pc + jimm; end
      7'b1100111: begin wr = 1'b1; wv = pc + 32'd4; r.npc = (a + iimm) & 32'hFFFF_FFFE; end
      7'b0110111: begin wr = 1'b1; wv = uimm; end
      7'b0010111: begin wr = 1'b1; wv = pc + uimm; end
      7'b0000011: begin r.is_mem = 1'b1; r.maddr = a + iimm; end
      7'b0100011: begin r.is_mem = 1'b1; r.maddr = a + simm; end
      7'b1110011: r.halt = 1'b1;
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) mregs[ins[11:7]] = wv;
    r.x1 = mregs[1];
  endtask

  task automatic send(input logic [31:0] ins, output ret_t r);
    bit ok = 1'b0;
    int n = 0;
    r = '0;
    while (!ok && n < 20) begin
      @(negedge CLK);
      bus.inst       = ins;
      bus.pc         = cur_pc;
      bus.inst_valid = 1'b1;
      ok = bus.inst_ready;
      n++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: inst_ready got 0 expected 1 for inst %h", ins);
    end else begin
      model_exec(ins, cur_pc, r);
      r.due = cyc + 2;
      q.push_back(r);
      cur_pc = r.npc;
    end
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    bus.inst_valid = 1'b0;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    bus.inst_valid = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Per-cycle compare against the model's retire queue.
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (started) begin
        if (RESET) begin
          chk("ready_in_reset", {31'd0, bus.inst_ready}, 32'd0);
          chk("done_in_reset", {31'd0, bus.done}, 32'd0);
          q.delete();
          exp_halt = 1'b0;
          exp_npc  = RESET_PC;
          exp_x1   = 32'd0;
        end else begin
          exp_done = (q.size() != 0) && (q[0].due == cyc);
          chk("done", {31'd0, bus.done}, {31'd0, exp_done});
          chk("inst_ready", {31'd0, bus.inst_ready}, {31'd0, (q.size() == 0) && !exp_halt});
          chk("halt", {31'd0, bus.halt}, {31'd0, exp_halt});
          chk("dbg_x1", bus.dbg_x1, exp_x1);
          if (exp_done) begin
            head = q.pop_front();
            chk("next_pc", bus.next_pc, head.npc);
            chk("is_mem", {31'd0, bus.is_mem}, {31'd0, head.is_mem});
            if (head.is_mem) begin
              chk("mem_addr", bus.mem_addr, head.maddr);
              chk("store_data", bus.store_data, head.sdata);
            end
            exp_npc  = head.npc;
            exp_x1   = head.x1;
            exp_halt = head.halt;
          end else begin
            chk("next_pc_hold", bus.next_pc, exp_npc);
            chk("is_mem_idle", {31'd0, bus.is_mem}, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ret_t r;
    logic [31:0] pc_save;
    bus.inst_valid = 1'b0;
    bus.inst       = 32'd0;
    bus.pc         = 32'd0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    repeat (2) @(negedge CLK);
    started = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;

    // counting x1 with inst_valid held high
    cur_pc = 32'h0;
    send(enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI), r);
    chk("lit_x1_1", r.x1, 32'd1);
    chk("lit_npc_4", r.npc, 32'd4);
    for (int k = 2; k <= 4; k++) begin
      send(enc_i(12'd1, 5'd1, 3'd0, 5'd1, OPI), r);
      chk("lit_x1_inc", r.x1, k);
      chk("lit_npc_inc", r.npc, 4 * k);
    end

    // ALU signed/unsigned corner cases, observed through stores
    send(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI), r);
    send(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OPI), r);
    send(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), r);
    send(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd4), r);
    send(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd5), r);
    send(enc_i(12'h401, 5'd2, 3'd5, 5'd6, OPI), r);
    send(enc_i(12'd4, 5'd1, 3'd1, 5'd11, OPI), r);
    send(enc_i(12'd28, 5'd2, 3'd5, 5'd12, OPI), r);
    send(enc_s(12'd16, 5'd3, 5'd1), r);
    chk("lit_sub", r.sdata, 32'd8);
    chk("lit_sw_addr", r.maddr, 32'h15);
    send(enc_s(12'd0, 5'd4, 5'd0), r);
    chk("lit_slt", r.sdata, 32'd1);
    send(enc_s(12'd0, 5'd5, 5'd0), r);
    chk("lit_sltu", r.sdata, 32'd0);
    send(enc_s(12'd0, 5'd6, 5'd0), r);
    chk("lit_srai", r.sdata, 32'hFFFF_FFFE);
    send(enc_s(12'd0, 5'd11, 5'd0), r);
    chk("lit_slli", r.sdata, 32'h50);
    send(enc_s(12'd0, 5'd12, 5'd0), r);
    chk("lit_srli", r.sdata, 32'hF);
    send(enc_i(12'd4, 5'd1, 3'd2, 5'd9, 7'b0000011), r);
    chk("lit_lw_addr", r.maddr, 32'd9);
    send(enc_s(12'd0, 5'd9, 5'd0), r);
    chk("lit_load_nowrite", r.sdata, 32'd0);

    // branches
    idle(2);
    cur_pc = 32'h20;
    send(enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0), r);
    chk("lit_beq", r.npc, 32'h18);
    send(enc_b(13'd16, 5'd0, 5'd0, 3'd1), r);
    chk("lit_bne", r.npc, 32'h1C);
    send(enc_b(13'd12, 5'd1, 5'd2, 3'd4), r);
    chk("lit_blt", r.npc, 32'h28);
    send(enc_b(13'd12, 5'd1, 5'd2, 3'd6), r);
    chk("lit_bltu", r.npc, 32'h2C);
    send(enc_b(13'd8, 5'd2, 5'd1, 3'd5), r);
    chk("lit_bge", r.npc, 32'h34);
    send(enc_b(13'd8, 5'd0, 5'd0, 3'd2), r);
    chk("lit_b010", r.npc, 32'h38);

    // jumps
    cur_pc = 32'h40;
    send(enc_j(21'h100, 5'd1), r);
    chk("lit_jal_x1", r.x1, 32'h44);
    chk("lit_jal_npc", r.npc, 32'h140);
    send(enc_i(12'd3, 5'd1, 3'd0, 5'd1, 7'b1100111), r);
    chk("lit_jalr_npc", r.npc, 32'h46);
    chk("lit_jalr_x1", r.x1, 32'h144);

    // x0, LUI, AUIPC, unknown opcode
    cur_pc = 32'h100;
    send(enc_i(12'd7, 5'd0, 3'd0, 5'd0, OPI), r);
    send(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), r);
    send(enc_s(12'd0, 5'd7, 5'd0), r);
    chk("lit_x0", r.sdata, 32'd0);
    send({20'h12345, 5'd8, 7'b0110111}, r);
    send(enc_s(12'd0, 5'd8, 5'd0), r);
    chk("lit_lui", r.sdata, 32'h1234_5000);
    pc_save = cur_pc;
    send({20'h00001, 5'd9, 7'b0010111}, r);
    send(enc_s(12'd0, 5'd9, 5'd0), r);
    chk("lit_auipc", r.sdata, pc_save + 32'h1000);
    pc_save = cur_pc;
    send(32'h0000_00FF, r);
    chk("lit_unknown_npc", r.npc, pc_save + 32'd4);

    // halt, then held request is ignored until reset
    send(32'h0010_0073, r);
    chk("lit_halt", {31'd0, r.halt}, 32'd1);
    @(negedge CLK);
    bus.inst = enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI);
    repeat (8) @(negedge CLK);
    do_reset();
    idle(2);
    cur_pc = 32'h0;
    send(enc_i(12'd9, 5'd1, 3'd0, 5'd1, OPI), r);
    chk("lit_cleared_x1", r.x1, 32'd9);

    // reset during READ aborts the instruction
    send(enc_i(12'h55, 5'd0, 3'd0, 5'd1, OPI), r);
    do_reset();
    idle(6);
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
